// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a pipelined cache port.
// Read responses are routed back in order using a small owner-ID FIFO.
module mem_arbiter #(
    parameter int AW    = 25,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [AW-1:0]     m0_addr,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic              m0_readdata_valid,

    input  logic [AW-1:0]     m1_addr,
    input  logic [DW/8-1:0]   m1_byte_en,
    input  logic [DW-1:0]     m1_writedata,
    input  logic              m1_read,
    input  logic              m1_write,
    output logic              m1_waitrequest,
    output logic              m1_readdata_valid,

    output logic [DW-1:0]     m_readdata,

    output logic [AW-1:0]     s_addr,
    output logic [DW/8-1:0]   s_byte_en,
    output logic [DW-1:0]     s_writedata,
    output logic              s_read,
    output logic              s_write,
    input  logic [DW-1:0]     s_readdata,
    input  logic              s_readdata_valid,
    input  logic              s_waitrequest,

    output logic              busy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_LOCK_M0 = 2'd1,
        ARB_LOCK_M1 = 2'd2
    } arbState_e;

    arbState_e stateQ, stateD;
    logic      lastM1Q, lastM1D;

    logic          ownerMemQ [DEPTH];
    logic [PW-1:0] wrPtrQ, wrPtrD;
    logic [PW-1:0] rdPtrQ, rdPtrD;
    logic [CW-1:0] countQ, countD;

    logic m0Req, m1Req;
    logic fifoFull, fifoEmpty;
    logic grantValid, grantM1;
    logic push, pop;
    logic headOwner;

    assign m0Req     = m0_read;
    assign m1Req     = m1_read | m1_write;
    assign fifoFull  = (countQ == FULL_COUNT);
    assign fifoEmpty = (countQ == '0);

    // A lock only holds while its owner keeps requesting; otherwise normal
    // round-robin applies. lastM1 moves only when the slave accepts.
    always_comb begin
        grantValid = 1'b0;
        grantM1    = 1'b0;
        stateD     = ARB_IDLE;
        lastM1D    = lastM1Q;
        if (!rst && !fifoFull && (m0Req || m1Req)) begin
            grantValid = 1'b1;
            if (stateQ == ARB_LOCK_M0 && m0Req) begin
                grantM1 = 1'b0;
            end else if (stateQ == ARB_LOCK_M1 && m1Req) begin
                grantM1 = 1'b1;
            end else if (m0Req && m1Req) begin
                grantM1 = !lastM1Q;
            end else begin
                grantM1 = m1Req;
            end
            if (s_waitrequest) begin
                stateD = grantM1 ? ARB_LOCK_M1 : ARB_LOCK_M0;
            end else begin
                lastM1D = grantM1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= ARB_IDLE;
            lastM1Q <= 1'b1;
        end else begin
            stateQ  <= stateD;
            lastM1Q <= lastM1D;
        end
    end

    always_comb begin
        s_addr         = grantM1 ? m1_addr : m0_addr;
        s_byte_en      = grantM1 ? m1_byte_en : '0;
        s_writedata    = grantM1 ? m1_writedata : '0;
        s_read         = grantValid && (grantM1 ? m1_read : m0_read);
        s_write        = grantValid && grantM1 && m1_write;
        m0_waitrequest = (grantValid && !grantM1) ? s_waitrequest : 1'b1;
        m1_waitrequest = (grantValid &&  grantM1) ? s_waitrequest : 1'b1;
    end

    // Responses arriving with nothing outstanding are stray and dropped.
    assign push      = s_read && !s_waitrequest;
    assign pop       = !rst && s_readdata_valid && !fifoEmpty;
    assign headOwner = ownerMemQ[rdPtrQ];

    assign m0_readdata_valid = pop && !headOwner;
    assign m1_readdata_valid = pop &&  headOwner;
    assign m_readdata        = s_readdata;
    assign busy_o            = !rst && !fifoEmpty;

    always_comb begin
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        countD = countQ;
        if (push) begin
            wrPtrD = wrPtrQ + PW'(1);
        end
        if (pop) begin
            rdPtrD = rdPtrQ + PW'(1);
        end
        case ({push, pop})
            2'b10:   countD = countQ + CW'(1);
            2'b01:   countD = countQ - CW'(1);
            default: countD = countQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            countQ <= countD;
            if (push) begin
                ownerMemQ[wrPtrQ] <= grantM1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of arbitration and routing.
module tb_mem_arbiter;

    localparam int AW    = 25;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] m0_addr;
    logic          m0_read;
    logic          m0_waitrequest;
    logic          m0_readdata_valid;
    logic [AW-1:0] m1_addr;
    logic [BW-1:0] m1_byte_en;
    logic [DW-1:0] m1_writedata;
    logic          m1_read;
    logic          m1_write;
    logic          m1_waitrequest;
    logic          m1_readdata_valid;
    logic [DW-1:0] m_readdata;
    logic [AW-1:0] s_addr;
    logic [BW-1:0] s_byte_en;
    logic [DW-1:0] s_writedata;
    logic          s_read;
    logic          s_write;
    logic [DW-1:0] s_readdata;
    logic          s_readdata_valid;
    logic          s_waitrequest;
    logic          busy_o;

    mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_read(m0_read),
        .m0_waitrequest(m0_waitrequest), .m0_readdata_valid(m0_readdata_valid),
        .m1_addr(m1_addr), .m1_byte_en(m1_byte_en), .m1_writedata(m1_writedata),
        .m1_read(m1_read), .m1_write(m1_write),
        .m1_waitrequest(m1_waitrequest), .m1_readdata_valid(m1_readdata_valid),
        .m_readdata(m_readdata),
        .s_addr(s_addr), .s_byte_en(s_byte_en), .s_writedata(s_writedata),
        .s_read(s_read), .s_write(s_write),
        .s_readdata(s_readdata), .s_readdata_valid(s_readdata_valid),
        .s_waitrequest(s_waitrequest),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
    } resp_t;

    int    errors = 0;
    int    checks = 0;
    resp_t expQ[$];

    // Reference model: last accepted master, lock holder, outstanding owners.
    logic  mLastM1 = 1'b1;
    logic  mLock = 1'b0;
    logic  mLockOwner = 1'b0;
    logic  modelFifo[$];

    logic obsSRead, obsSWrite, obsW0, obsW1, obsBusy, obsRv0, obsRv1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic iRst, input logic iM0Read, input logic iM1Read,
                                 input logic iM1Write, input logic iSWait, input logic iSValid);
        logic req0, req1, granted, g, expRead, expWrite, popExp;
        @(negedge clk);
        rst              = iRst;
        m0_read          = iM0Read;
        m1_read          = iM1Read;
        m1_write         = iM1Write;
        m0_addr          = AW'($urandom);
        m1_addr          = AW'($urandom);
        m1_byte_en       = BW'($urandom);
        m1_writedata     = DW'($urandom);
        s_waitrequest    = iSWait;
        s_readdata_valid = iSValid;
        s_readdata       = DW'($urandom);
        #1;
        obsSRead  = s_read;
        obsSWrite = s_write;
        obsW0     = m0_waitrequest;
        obsW1     = m1_waitrequest;
        obsBusy   = busy_o;
        obsRv0    = m0_readdata_valid;
        obsRv1    = m1_readdata_valid;

        req0    = iM0Read;
        req1    = iM1Read | iM1Write;
        granted = 1'b0;
        g       = 1'b0;
        if (!iRst && modelFifo.size() < DEPTH && (req0 || req1)) begin
            granted = 1'b1;
            if (mLock && (mLockOwner ? req1 : req0)) g = mLockOwner;
            else if (req0 && req1)                   g = !mLastM1;
            else                                     g = req1;
        end
        expRead  = granted && (g ? iM1Read : iM0Read);
        expWrite = granted && g && iM1Write;

        checkOutput("s_read", 64'(s_read), 64'(expRead));
        checkOutput("s_write", 64'(s_write), 64'(expWrite));
        if (req0 || iRst)
            checkOutput("m0_waitrequest", 64'(m0_waitrequest), 64'((granted && !g) ? iSWait : 1'b1));
        if (req1 || iRst)
            checkOutput("m1_waitrequest", 64'(m1_waitrequest), 64'((granted && g) ? iSWait : 1'b1));
        if (granted) begin
            checkOutput("s_addr", 64'(s_addr), 64'(g ? m1_addr : m0_addr));
            checkOutput("s_byte_en", 64'(s_byte_en), 64'(g ? m1_byte_en : '0));
            checkOutput("s_writedata", 64'(s_writedata), 64'(g ? m1_writedata : '0));
        end
        checkOutput("busy_o", 64'(busy_o), 64'(!iRst && modelFifo.size() > 0));

        popExp = !iRst && iSValid && modelFifo.size() > 0;
        checkOutput("rdvalid_any", 64'(m0_readdata_valid | m1_readdata_valid), 64'(popExp));
        if (popExp) begin
            expQ.push_back('{owner: modelFifo[0], data: s_readdata});
            void'(modelFifo.pop_front());
        end

        @(posedge clk);
        if (iRst) begin
            modelFifo.delete();
            mLock   = 1'b0;
            mLastM1 = 1'b1;
        end else if (granted && iSWait) begin
            mLock      = 1'b1;
            mLockOwner = g;
        end else begin
            mLock = 1'b0;
            if (granted) begin
                mLastM1 = g;
                if (expRead) modelFifo.push_back(g);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && modelFifo.size() > 0; i++)
            applyStimulus(0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: every response the DUT presents must match the scoreboard head.
    always begin
        resp_t e;
        @(negedge clk);
        #2;
        if (m0_readdata_valid && m1_readdata_valid) begin
            checkOutput("rdvalid_onehot", 64'({m0_readdata_valid, m1_readdata_valid}), 64'(1));
        end else if (m0_readdata_valid || m1_readdata_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("rdvalid_unexpected", 64'(1), 64'(0));
            end else begin
                e = expQ.pop_front();
                checkOutput("rd_owner", 64'(m1_readdata_valid), 64'(e.owner));
                checkOutput("rd_data", 64'(m_readdata), 64'(e.data));
            end
        end
    end

    initial begin
        rst = 1'b1; m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        m0_addr = '0; m1_addr = '0; m1_byte_en = '0; m1_writedata = '0;
        s_readdata = '0; s_readdata_valid = 1'b0; s_waitrequest = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 1);
        checkOutput("rst_w0", 64'(obsW0), 64'(1));
        checkOutput("rst_w1", 64'(obsW1), 64'(1));
        checkOutput("rst_sread", 64'(obsSRead), 64'(0));

        // Round-robin after reset: m0 first, then alternate.
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("rr_c1_m0", 64'({obsW0, obsW1}), 64'(2'b01));
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("rr_c2_m1", 64'({obsW0, obsW1}), 64'(2'b10));
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("rr_c3_m0", 64'({obsW0, obsW1}), 64'(2'b01));
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("rr_c4_m1", 64'({obsW0, obsW1}), 64'(2'b10));
        drain();

        // Lock held on an m1 write across slave stalls.
        applyStimulus(0, 1, 0, 0, 0, 0);
        drain();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 1, 1, 0);
            checkOutput("lock_w0", 64'(obsW0), 64'(1));
            checkOutput("lock_swrite", 64'(obsSWrite), 64'(1));
        end
        applyStimulus(0, 1, 0, 1, 0, 0);
        checkOutput("lock_c4_w0", 64'(obsW0), 64'(1));
        checkOutput("lock_c4_w1", 64'(obsW1), 64'(0));
        applyStimulus(0, 1, 0, 1, 0, 0);
        checkOutput("lock_c5_m0", 64'({obsW0, obsSRead, obsSWrite}), 64'(3'b010));
        drain();

        // Fill the FIFO; further requests stall until one response returns.
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            checkOutput("full_busy", 64'(obsBusy), 64'(1));
            checkOutput("full_stall", 64'({obsSRead, obsW0}), 64'(2'b01));
        end
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("full_pop", 64'({obsSRead, obsW0, obsRv0}), 64'(3'b011));
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("full_resume", 64'({obsSRead, obsW0}), 64'(2'b10));
        drain();

        // In-order routing of interleaved reads.
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("order_1", 64'({obsRv0, obsRv1}), 64'(2'b10));
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("order_2", 64'({obsRv0, obsRv1}), 64'(2'b01));
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("order_3", 64'({obsRv0, obsRv1}), 64'(2'b10));

        // Stray response with nothing outstanding.
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("stray_rv", 64'({obsRv0, obsRv1, obsBusy}), 64'(0));
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("stray_busy", 64'(obsBusy), 64'(0));

        // Reset with reads in flight drops the late responses.
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("inflight_busy", 64'(obsBusy), 64'(1));
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("postrst_c1", 64'({obsBusy, obsRv0, obsRv1}), 64'(0));
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("postrst_c2", 64'({obsBusy, obsRv0, obsRv1}), 64'(0));

        // Randomized traffic with stalls, dropped requests and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            int op;
            op = int'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 99) == 0),
                          1'($urandom_range(0, 1)),
                          (op == 1 || op == 3),
                          (op == 2),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 2) == 0));
        end
        drain();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("sb_empty", 64'(expQ.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 25, cache address width.
REQ-002 SHALL have parameter DW, default 32, cache data width; byte-enable width is DW/8.
REQ-003 SHALL have parameter DEPTH, default 4, maximum outstanding reads (power of two, at least 2).
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port m0_addr  input  AW  instruction-fetch read address.
REQ-007 SHALL have port m0_read  input  1  instruction-fetch read request.
REQ-008 SHALL have port m0_waitrequest  output  1  instruction-fetch stall.
REQ-009 SHALL have port m0_readdata_valid  output  1  instruction-fetch read data valid.
REQ-010 SHALL have port m1_addr  input  AW  load/store address.
REQ-011 SHALL have port m1_byte_en  input  DW/8  load/store write byte mask.
REQ-012 SHALL have port m1_writedata  input  DW  load/store write data.
REQ-013 SHALL have port m1_read  input  1  load/store read request.
REQ-014 SHALL have port m1_write  input  1  load/store write request.
REQ-015 SHALL have port m1_waitrequest  output  1  load/store stall.
REQ-016 SHALL have port m1_readdata_valid  output  1  load/store read data valid.
REQ-017 SHALL have port m_readdata  output  DW  read data, broadcast to both masters.
REQ-018 SHALL have port s_addr  output  AW  cache address.
REQ-019 SHALL have port s_byte_en  output  DW/8  cache byte mask.
REQ-020 SHALL have port s_writedata  output  DW  cache write data.
REQ-021 SHALL have port s_read  output  1  cache read enable.
REQ-022 SHALL have port s_write  output  1  cache write enable.
REQ-023 SHALL have port s_readdata  input  DW  cache read data.
REQ-024 SHALL have port s_readdata_valid  input  1  cache read data valid.
REQ-025 SHALL have port s_waitrequest  input  1  cache stall.
REQ-026 SHALL have port busy_o  output  1  asserted while the outstanding count is nonzero.

Function
REQ-027 SHALL define a request: m0 requests when m0_read=1; m1 requests when m1_read or m1_write is 1.
REQ-028 SHALL, when unlocked and both masters request, grant the master not granted most recently (round-robin); a single requester is granted directly.
REQ-029 SHALL drive s_addr, s_byte_en, s_writedata, s_read and s_write combinationally from the granted master; for m0, s_byte_en=0, s_writedata=0 and s_write=0.
REQ-030 SHALL pass s_waitrequest to the granted master and drive waitrequest=1 to every non-granted requester.
REQ-031 SHALL lock the grant while s_waitrequest=1 with a request issued; the lock releases on the cycle the slave accepts (s_waitrequest=0).
REQ-032 SHALL release the lock without an access if the locked master drops its request.
REQ-033 SHALL, on each accepted read (s_read=1 and s_waitrequest=0), push the owner ID (0 or 1) into a DEPTH-entry in-order FIFO.
REQ-034 SHALL push nothing for writes.
REQ-035 SHALL, on s_readdata_valid=1, pop the FIFO head and assert readdata_valid only to that owner, in the same cycle.
REQ-036 SHALL pass m_readdata = s_readdata combinationally.
REQ-037 SHALL, when the FIFO is full, issue no grant: s_read=0, s_write=0, and waitrequest=1 to all requesters.
REQ-038 SHALL, on a simultaneous push and pop, leave the count unchanged, with pointers wrapping modulo DEPTH.
REQ-039 SHALL ignore s_readdata_valid while the FIFO is empty: neither readdata_valid is asserted and state is unchanged.
REQ-040 SHALL update the last-granted record only on an accepted access (read or write).

Reset
REQ-041 SHALL, while rst=1, clear the FIFO pointers and count, clear the lock, set last-granted to m1, force s_read=s_write=0 and m0_waitrequest=m1_waitrequest=1, and keep both readdata_valid=0 and busy_o=0.
REQ-042 SHALL discard any reads in flight when rst is asserted mid-operation; their later responses fall under REQ-039.

Verification
REQ-043 SHALL verify: after reset, m0_read and m1_read are both 1 with s_waitrequest=0 -> m0 is granted first, m1 the next cycle, and the grants alternate thereafter.
REQ-044 SHALL verify: m1_write with s_waitrequest=1 for 3 cycles while m0_read=1 -> the grant stays on m1 for 4 cycles, m0_waitrequest=1 throughout, and m0 is granted in cycle 5.
REQ-045 SHALL verify: 4 m0 reads accepted with no response -> busy_o=1, the FIFO is full, and a fifth request sees waitrequest=1 with s_read=0 until one s_readdata_valid arrives.
REQ-046 SHALL verify: interleaved reads issued in order m0, m1, m0 -> three s_readdata_valid pulses produce m0_readdata_valid, m1_readdata_valid, m0_readdata_valid in that order.
REQ-047 SHALL verify: s_readdata_valid=1 with the FIFO empty -> no readdata_valid to either master and busy_o stays 0.
REQ-048 SHALL verify: rst pulsed with 2 reads outstanding -> busy_o=0 on the next cycle and the late responses are dropped.
